// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/hold control for load-use, branch, jump and slow memory; `HAZARD_PERF_EN adds perf counters
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  i_id_rs,
  input  logic [5:0]  i_id_rt,
  input  logic        i_id_uses_rt,
  input  logic        i_ex_mem_read,
  input  logic [5:0]  i_ex_rt,
  input  logic        i_ex_branch_taken,
  input  logic        i_id_jump,
  input  logic        i_mem_busy,
  output logic        o_pc_write,
  output logic        o_if_id_write,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_pipe_hold,
  output logic [1:0]  o_state,
  output logic        o_mem_timeout,
  output logic [15:0] o_stall_cnt,
  output logic [15:0] o_flush_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL_LD = 2'd1, WAIT_MEM = 2'd2} state_t;
  state_t state, state_nxt;
  logic [7:0] wait_cnt;
  logic load_use, tmo, tmo_hit;
  assign load_use = i_ex_mem_read && i_ex_rt != 6'd0 &&
                    (i_ex_rt == i_id_rs || (i_id_uses_rt && i_ex_rt == i_id_rt));
  // the watchdog counts the current wait cycle too, so the flag shows during the 255th one
  assign tmo_hit = state == WAIT_MEM && wait_cnt >= 8'd254;
  assign o_mem_timeout = tmo | tmo_hit;
  assign o_state = state;
  // priority decode: busy > branch > load-use (masked in STALL_LD) > jump; everything off in reset
  always_comb begin
    o_pc_write = 1'b1;
    o_if_id_write = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_pipe_hold = 1'b0;
    state_nxt = RUN;
    if (!reset_n) begin
      o_pc_write = 1'b0;
      o_if_id_write = 1'b0;
    end else if (i_mem_busy) begin
      o_pc_write = 1'b0;
      o_if_id_write = 1'b0;
      o_pipe_hold = 1'b1;
      state_nxt = WAIT_MEM;
    end else if (i_ex_branch_taken) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (load_use && state != STALL_LD) begin
      o_pc_write = 1'b0;
      o_if_id_write = 1'b0;
      o_id_ex_flush = 1'b1;
      state_nxt = state == RUN ? STALL_LD : RUN;
    end else if (i_id_jump) begin
      o_if_id_flush = 1'b1;
    end
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= RUN;
    else state <= state_nxt;
  // wait counter cleared on entry, saturating; sticky timeout flag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wait_cnt <= 8'd0;
      tmo <= 1'b0;
    end else begin
      if (state != WAIT_MEM && state_nxt == WAIT_MEM) wait_cnt <= 8'd0;
      else if (state == WAIT_MEM && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
      tmo <= tmo | tmo_hit;
    end
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
  // saturating counters of stall cycles and bubble-inserting cycles
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (!o_pc_write && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if ((o_if_id_flush || o_id_ex_flush) && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  assign o_stall_cnt = stall_cnt;
  assign o_flush_cnt = flush_cnt;
`else
  assign o_stall_cnt = 16'd0;
  assign o_flush_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: random + directed stimulus checked every cycle against a behavioural model
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [5:0] id_rs = 6'd0, id_rt = 6'd0, ex_rt = 6'd0;
  logic id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch = 1'b0, jump = 1'b0, busy = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_timeout;
  logic [1:0] state;
  logic [15:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  int m_state = 0, m_wdone = 0, m_stall = 0, m_flush = 0;
  int n_state = 0, n_wdone = 0, n_stall = 0, n_flush = 0;
  bit m_tmo = 0, n_tmo = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_branch_taken(branch), .i_id_jump(jump),
    .i_mem_busy(busy), .o_pc_write(pc_write), .o_if_id_write(if_id_write),
    .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush), .o_pipe_hold(pipe_hold),
    .o_state(state), .o_mem_timeout(mem_timeout), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model state: commit at each clock, wiped by async reset
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_state = 0; m_wdone = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_state = n_state; m_wdone = n_wdone; m_tmo = n_tmo; m_stall = n_stall; m_flush = n_flush;
    end
  // every-cycle compare against the model's expectations
  always @(negedge clk) begin
    bit lu, e_pc, e_ifw, e_iff, e_idf, e_hold, hit;
    int this_wait;
    lu = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)) && m_state != 1;
    {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b11000;
    n_state = 0;
    if (!reset_n) {e_pc, e_ifw} = 2'b00;
    else if (busy) begin
      {e_pc, e_ifw, e_hold} = 3'b001; n_state = 2;
    end else if (branch) {e_iff, e_idf} = 2'b11;
    else if (lu) begin
      {e_pc, e_ifw, e_idf} = 3'b001; n_state = m_state == 0 ? 1 : 0;
    end else if (jump) e_iff = 1;
    this_wait = m_state == 2 ? m_wdone + 1 : 0;
    hit = m_state == 2 && this_wait >= 255;
    n_wdone = this_wait;
    n_tmo = m_tmo | hit;
    n_stall = m_stall + ((!e_pc && m_stall < 65535) ? 1 : 0);
    n_flush = m_flush + (((e_iff || e_idf) && m_flush < 65535) ? 1 : 0);
    chk("pc_write", 16'(pc_write), 16'(e_pc));
    chk("if_id_write", 16'(if_id_write), 16'(e_ifw));
    chk("if_id_flush", 16'(if_id_flush), 16'(e_iff));
    chk("id_ex_flush", 16'(id_ex_flush), 16'(e_idf));
    chk("pipe_hold", 16'(pipe_hold), 16'(e_hold));
    chk("state", 16'(state), 16'(m_state));
    chk("mem_timeout", 16'(mem_timeout), 16'(m_tmo | hit));
`ifdef HAZARD_PERF_EN
    chk("stall_cnt", stall_cnt, 16'(m_stall));
    chk("flush_cnt", flush_cnt, 16'(m_flush));
`else
    chk("stall_cnt", stall_cnt, 16'd0);
    chk("flush_cnt", flush_cnt, 16'd0);
`endif
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {ex_mem_read, branch, jump, busy, id_uses_rt} = 5'b0;
    {id_rs, id_rt, ex_rt} = {6'd1, 6'd2, 6'd3};
  endtask
  task automatic ld_hazard();
    idle();
    {ex_mem_read, ex_rt, id_rs} = {1'b1, 6'd5, 6'd5};
  endtask
  initial begin
    idle();
    repeat (2) cyc();
    @(negedge clk);
    chk("lit_rst_pc", 16'(pc_write), 16'd0);
    chk("lit_rst_state", 16'(state), 16'd0);
    cyc(); reset_n = 1'b1;
    cyc(); ld_hazard();
    @(negedge clk);
    chk("lit_lu_pc", 16'(pc_write), 16'd0);
    chk("lit_lu_idex", 16'(id_ex_flush), 16'd1);
    cyc(); idle();
    @(negedge clk);
    chk("lit_lu_state", 16'(state), 16'd1);
    cyc();
    @(negedge clk);
    chk("lit_lu_back_run", 16'(state), 16'd0);
    {ex_mem_read, ex_rt, id_rs} = {1'b1, 6'd0, 6'd0};
    cyc();
    @(negedge clk);
    chk("lit_r0_no_stall", 16'(pc_write), 16'd1);
    cyc(); ld_hazard(); branch = 1'b1;
    @(negedge clk);
    chk("lit_br_flushes", 16'({if_id_flush, id_ex_flush, pc_write}), 16'b111);
    cyc(); idle();
    @(negedge clk);
    chk("lit_br_no_stall", 16'(state), 16'd0);
    cyc(); busy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("lit_busy_hold", 16'(pipe_hold), 16'd1);
      if (k > 1) chk("lit_busy_state", 16'(state), 16'd2);
      cyc();
    end
    busy = 1'b0;
    @(negedge clk);
    chk("lit_busy_release", 16'({pipe_hold, pc_write}), 16'b01);
    cyc();
    @(negedge clk);
    chk("lit_busy_run", 16'(state), 16'd0);
    chk("lit_busy_no_tmo", 16'(mem_timeout), 16'd0);
    cyc(); busy = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 255) chk("lit_tmo_254", 16'(mem_timeout), 16'd0);
      if (k == 256) chk("lit_tmo_255", 16'(mem_timeout), 16'd1);
      cyc();
    end
    busy = 1'b0;
    cyc();
    @(negedge clk);
    chk("lit_tmo_sticky", 16'(mem_timeout), 16'd1);
    cyc(); busy = 1'b1;
    repeat (3) cyc();
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("lit_rst_wait_state", 16'(state), 16'd0);
    chk("lit_rst_tmo", 16'(mem_timeout), 16'd0);
    chk("lit_rst_cnts", stall_cnt | flush_cnt, 16'd0);
    cyc(); reset_n = 1'b1; busy = 1'b0;
    cyc(); ld_hazard();
    cyc(); idle();
    cyc(); ld_hazard();
    cyc(); idle();
    cyc(); branch = 1'b1;
    cyc(); idle();
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    chk("lit_perf_stall", stall_cnt, 16'd2);
    chk("lit_perf_flush", flush_cnt, 16'd3);
`else
    chk("lit_perf_off", stall_cnt | flush_cnt, 16'd0);
`endif
    for (int k = 0; k < 3000; k++) begin
      cyc();
      id_rs = 6'($urandom_range(0, 3));
      id_rt = 6'($urandom_range(0, 3));
      ex_rt = 6'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_mem_read = $urandom_range(0, 2) != 0;
      branch = $urandom_range(0, 5) == 0;
      jump = $urandom_range(0, 4) == 0;
      busy = $urandom_range(0, 9) == 0 || (busy && $urandom_range(0, 3) != 0);
      if (k > 200 && k < 600) busy = 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_n = 1'b0;
      end else reset_n = 1'b1;
    end
    cyc(); reset_n = 1'b1; idle();
    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
